app_mem_resp: RTL and testbench

APP_MEM_RESP -- requirements
Module: app_mem_resp

---
 rtl/app_mem_resp_pkg.sv | 23 ++
 rtl/app_mem_ram.sv | 35 +++
 rtl/app_mem_resp.sv | 190 +++++++++++++++++++
 tb/tb_app_mem_resp.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/app_mem_resp_pkg.sv
// Shared types and command encodings for the app_mem_resp memory responder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: APP_CMD_* encodings (the rvm command constants), FSM state enum,
// write-data buffer record.
package app_mem_resp_pkg;

   // Command encodings shared with the rest of the rvm codebase.
   localparam logic [2:0] APP_CMD_WRITE = 3'b000;
   localparam logic [2:0] APP_CMD_READ  = 3'b001;

   typedef enum logic {
      ST_IDLE       = 1'b0,
      ST_WAIT_WDATA = 1'b1
   } app_state_e;

   // One buffered write beat that arrived ahead of its command.
   typedef struct packed {
      logic [127:0] dat;
      logic [15:0]  msk;
   } wbuf_t;

endpackage

// File: rtl/app_mem_ram.sv
// Byte-enabled 128-bit storage array with one write port and one read port.
// Latency: write lands at the clock edge; read data registered 1 cycle after rd_en.
// Backpressure: none, accepts one read and one write every cycle.
// Ports: clk; wr_en/wr_be/wr_addr/wr_dat write port; rd_en/rd_addr -> rd_dat.
// Contents are never reset. A read and write to the same address in the same
// cycle returns the pre-write contents.
module app_mem_ram #(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [15:0]           wr_be,
   input  logic [DEPTH_LOG2-1:0] wr_addr,
   input  logic [127:0]          wr_dat,
   input  logic                  rd_en,
   input  logic [DEPTH_LOG2-1:0] rd_addr,
   output logic [127:0]          rd_dat
);

   logic [127:0] mem [2**DEPTH_LOG2];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 16; b++) begin
            if (wr_be[b]) begin
               mem[wr_addr][b*8 +: 8] <= wr_dat[b*8 +: 8];
            end
         end
      end
      if (rd_en) begin
         rd_dat <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/app_mem_resp.sv
// Memory responder behind an app_* style command/write-data/read-data interface.
// Latency: reads return RD_LATENCY cycles after acceptance; writes commit at the edge both cmd and data are present.
// Backpressure: app_rdy low only while a write command waits for data; app_wdf_rdy low while one beat is buffered.
// Ports: clk, resetn (async, active-low); app_addr/app_cmd/app_en command;
// app_wdf_* write data (app_wdf_end ignored); app_rdy, app_wdf_rdy handshakes;
// app_rd_data/_valid/_end read return; err_cmd, err_range sticky flags.
// Build option: define APP_MEM_RANGE_CHECK_EN to flag and suppress accesses with
// app_addr[27:DEPTH_LOG2] != 0; otherwise addresses wrap and err_range is 0.
module app_mem_resp
   import app_mem_resp_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10,
   parameter int RD_LATENCY = 2
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic [27:0]  app_addr,
   input  logic [2:0]   app_cmd,
   input  logic         app_en,
   input  logic [127:0] app_wdf_data,
   input  logic [15:0]  app_wdf_mask,
   input  logic         app_wdf_wren,
   input  logic         app_wdf_end,
   output logic         app_rdy,
   output logic         app_wdf_rdy,
   output logic [127:0] app_rd_data,
   output logic         app_rd_data_valid,
   output logic         app_rd_data_end,
   output logic         err_cmd,
   output logic         err_range
);

   app_state_e            state_q, state_d;
   logic                  buf_full_q;
   wbuf_t                 buf_q;
   logic [DEPTH_LOG2-1:0] pend_addr_q;
   logic                  pend_oor_q;

   logic                  cmd_acc, wd_acc, is_wr, is_rd, rd_acc;
   logic                  addr_oor;
   logic                  buf_load, buf_drain;
   logic                  ram_we;
   logic [15:0]           ram_be;
   logic [DEPTH_LOG2-1:0] ram_waddr;
   logic [127:0]          ram_wdat;
   logic [127:0]          ram_q;

   // rd_vld_q[k] is high k cycles after a read was accepted; rd_dly_q[k]
   // carries the data that belongs to rd_vld_q[k+1].
   logic [RD_LATENCY:0]   rd_vld_q;
   logic                  rd_oor_q;
   logic [127:0]          rd_dly_q [RD_LATENCY];

   logic                  unused_in;

`ifdef APP_MEM_RANGE_CHECK_EN
   assign addr_oor  = |app_addr[27:DEPTH_LOG2];
   assign unused_in = app_wdf_end;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         err_range <= 1'b0;
      end else if (cmd_acc && (is_wr || is_rd) && addr_oor) begin
         err_range <= 1'b1;
      end
   end
`else
   assign addr_oor  = 1'b0;
   assign err_range = 1'b0;
   assign unused_in = ^{app_wdf_end, app_addr[27:DEPTH_LOG2]};
`endif

   assign app_rdy     = (state_q == ST_IDLE);
   assign app_wdf_rdy = !buf_full_q;
   assign cmd_acc     = app_en && app_rdy;
   assign wd_acc      = app_wdf_wren && app_wdf_rdy;
   assign is_wr       = (app_cmd == APP_CMD_WRITE);
   assign is_rd       = (app_cmd == APP_CMD_READ);
   assign rd_acc      = cmd_acc && is_rd;

   always_comb begin
      state_d   = state_q;
      ram_we    = 1'b0;
      ram_be    = app_wdf_mask;
      ram_waddr = app_addr[DEPTH_LOG2-1:0];
      ram_wdat  = app_wdf_data;
      buf_load  = 1'b0;
      buf_drain = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_acc && is_wr) begin
               if (wd_acc) begin
                  // Data arriving with the command wins; buffer is empty here anyway.
                  ram_we = !addr_oor;
               end else if (buf_full_q) begin
                  ram_we    = !addr_oor;
                  ram_be    = buf_q.msk;
                  ram_wdat  = buf_q.dat;
                  buf_drain = 1'b1;
               end else begin
                  state_d = ST_WAIT_WDATA;
               end
            end else if (wd_acc) begin
               buf_load = 1'b1;
            end
         end
         ST_WAIT_WDATA: begin
            // Buffer is always empty in this state, so wdf_rdy is high.
            ram_waddr = pend_addr_q;
            if (wd_acc) begin
               ram_we  = !pend_oor_q;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         buf_full_q  <= 1'b0;
         buf_q       <= '0;
         pend_addr_q <= '0;
         pend_oor_q  <= 1'b0;
         err_cmd     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (buf_load) begin
            buf_full_q <= 1'b1;
            buf_q      <= '{dat: app_wdf_data, msk: app_wdf_mask};
         end else if (buf_drain) begin
            buf_full_q <= 1'b0;
         end
         if (cmd_acc && is_wr) begin
            pend_addr_q <= app_addr[DEPTH_LOG2-1:0];
            pend_oor_q  <= addr_oor;
         end
         if (cmd_acc && !is_wr && !is_rd) begin
            err_cmd <= 1'b1;
         end
      end
   end

   // Read latency pipeline. Each data stage loads only when its beat is valid,
   // so the last stage (app_rd_data) holds between returns.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_vld_q <= '0;
         rd_oor_q <= 1'b0;
         for (int k = 0; k < RD_LATENCY; k++) begin
            rd_dly_q[k] <= '0;
         end
      end else begin
         rd_vld_q[0] <= rd_acc;
         for (int k = 1; k <= RD_LATENCY; k++) begin
            rd_vld_q[k] <= rd_vld_q[k-1];
         end
         if (rd_acc) begin
            rd_oor_q <= addr_oor;
         end
         if (rd_vld_q[0]) begin
            rd_dly_q[0] <= rd_oor_q ? '0 : ram_q;
         end
         for (int k = 1; k < RD_LATENCY; k++) begin
            if (rd_vld_q[k]) begin
               rd_dly_q[k] <= rd_dly_q[k-1];
            end
         end
      end
   end

   assign app_rd_data       = rd_dly_q[RD_LATENCY-1];
   assign app_rd_data_valid = rd_vld_q[RD_LATENCY];
   assign app_rd_data_end   = rd_vld_q[RD_LATENCY];

   app_mem_ram #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_ram (
      .clk     (clk),
      .wr_en   (ram_we),
      .wr_be   (ram_be),
      .wr_addr (ram_waddr),
      .wr_dat  (ram_wdat),
      .rd_en   (rd_acc),
      .rd_addr (app_addr[DEPTH_LOG2-1:0]),
      .rd_dat  (ram_q)
   );

endmodule

// File: tb/tb_app_mem_resp.sv
// Bench for app_mem_resp: directed vector table, hand sequences, random traffic
// against a behavioural model (memory array + expected-read queue).
// Inputs change 1ns after the rising edge; outputs are checked at the falling edge.
module tb_app_mem_resp;
   import app_mem_resp_pkg::*;

   localparam int DL = 10;
   localparam int RL = 2;
`ifdef APP_MEM_RANGE_CHECK_EN
   localparam bit RANGE_EN = 1'b1;
`else
   localparam bit RANGE_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         resetn;
   logic [27:0]  app_addr;
   logic [2:0]   app_cmd;
   logic         app_en;
   logic [127:0] app_wdf_data;
   logic [15:0]  app_wdf_mask;
   logic         app_wdf_wren;
   logic         app_wdf_end;
   logic         app_rdy, app_wdf_rdy;
   logic [127:0] app_rd_data;
   logic         app_rd_data_valid, app_rd_data_end;
   logic         err_cmd, err_range;

   app_mem_resp #(.DEPTH_LOG2(DL), .RD_LATENCY(RL)) dut (
      .clk(clk), .resetn(resetn),
      .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
      .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
      .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
      .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
      .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
      .app_rd_data_end(app_rd_data_end),
      .err_cmd(err_cmd), .err_range(err_range)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   bit mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk1(string name, logic act, logic exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic chk128(string name, logic [127:0] act, logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [127:0] dat;
      int           cyc;
   } exp_t;

   logic [127:0] ref_mem [1024];
   exp_t         exp_q [$];
   bit           m_pend, m_buf, m_err_cmd, m_err_range;
   logic [27:0]  m_pend_addr;
   logic [127:0] m_buf_dat, m_last;
   logic [15:0]  m_buf_msk;

   function automatic bit oor(logic [27:0] a);
      return RANGE_EN && (a[27:DL] != '0);
   endfunction

   function automatic int idx(logic [27:0] a);
      return int'(a[DL-1:0]);
   endfunction

   task automatic model_write(logic [27:0] a, logic [127:0] d, logic [15:0] m);
      if (!oor(a)) begin
         for (int b = 0; b < 16; b++) begin
            if (m[b]) ref_mem[idx(a)][b*8 +: 8] = d[b*8 +: 8];
         end
      end
   endtask

   // Drive one cycle of stimulus, check handshakes against the model, then
   // update the model with what the coming edge must do.
   task automatic step(bit en, logic [2:0] cmd, logic [27:0] addr,
                       bit wren, logic [127:0] dat, logic [15:0] msk);
      bit cacc, wacc;
      int c0;
      app_en = en; app_cmd = cmd; app_addr = addr;
      app_wdf_wren = wren; app_wdf_data = dat; app_wdf_mask = msk; app_wdf_end = wren;
      chk1("app_rdy", app_rdy, !m_pend);
      chk1("app_wdf_rdy", app_wdf_rdy, !m_buf);
      cacc = en && !m_pend;
      wacc = wren && !m_buf;
      c0   = cyc;
      @(posedge clk);
      if (m_pend) begin
         if (wacc) begin
            model_write(m_pend_addr, dat, msk);
            m_pend = 1'b0;
         end
      end else if (cacc && cmd == APP_CMD_WRITE) begin
         if (oor(addr)) m_err_range = 1'b1;
         if (wacc) model_write(addr, dat, msk);
         else if (m_buf) begin
            model_write(addr, m_buf_dat, m_buf_msk);
            m_buf = 1'b0;
         end else begin
            m_pend = 1'b1;
            m_pend_addr = addr;
         end
      end else begin
         if (cacc && cmd == APP_CMD_READ) begin
            if (oor(addr)) m_err_range = 1'b1;
            exp_q.push_back('{oor(addr) ? 128'h0 : ref_mem[idx(addr)], c0 + 1});
         end else if (cacc) begin
            m_err_cmd = 1'b1;
         end
         if (wacc) begin
            m_buf = 1'b1; m_buf_dat = dat; m_buf_msk = msk;
         end
      end
      #1;
   endtask

   task automatic idle();
      step(1'b0, 3'b000, 28'h0, 1'b0, 128'h0, 16'h0);
   endtask

   // Output monitor: valid/end must appear exactly RL cycles after acceptance.
   always @(negedge clk) begin
      if (mon_en) begin
         bit   ev;
         exp_t e;
         ev = (exp_q.size() > 0) && (exp_q[0].cyc + RL == cyc);
         chk1("rd_valid", app_rd_data_valid, ev);
         chk1("rd_end", app_rd_data_end, ev);
         if (ev) begin
            e = exp_q.pop_front();
            m_last = e.dat;
         end
         chk128(ev ? "rd_data" : "rd_hold", app_rd_data, m_last);
         chk1("err_cmd", err_cmd, m_err_cmd);
         chk1("err_range", err_range, m_err_range);
      end
   end

   task automatic do_reset();
      app_en = 1'b0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
      resetn = 1'b0;
      m_pend = 0; m_buf = 0; m_err_cmd = 0; m_err_range = 0; m_last = '0;
      exp_q.delete();
      #1;
      chk1("rst_app_rdy", app_rdy, 1'b1);
      chk1("rst_app_wdf_rdy", app_wdf_rdy, 1'b1);
      chk128("rst_rd_data", app_rd_data, 128'h0);
      chk1("rst_rd_valid", app_rd_data_valid, 1'b0);
      chk1("rst_rd_end", app_rd_data_end, 1'b0);
      chk1("rst_err_cmd", err_cmd, 1'b0);
      chk1("rst_err_range", err_range, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   // Read one address in isolation and check the return by hand.
   task automatic rd_direct(string name, logic [27:0] a, logic [127:0] exp);
      step(1'b1, APP_CMD_READ, a, 1'b0, 128'h0, 16'h0);
      repeat (RL) idle();
      chk1({name, "_valid"}, app_rd_data_valid, 1'b1);
      chk128({name, "_data"}, app_rd_data, exp);
      idle();
      chk1({name, "_one_cycle"}, app_rd_data_valid, 1'b0);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit           en;
      logic [2:0]   cmd;
      logic [27:0]  addr;
      bit           wren;
      logic [127:0] dat;
      logic [15:0]  msk;
      bit           e_rdy;
      bit           e_wrdy;
   } vec_t;

   function automatic vec_t v(bit en, logic [2:0] cmd, logic [27:0] addr, bit wren,
                              logic [127:0] dat, logic [15:0] msk, bit e_rdy, bit e_wrdy);
      vec_t r;
      r.en = en; r.cmd = cmd; r.addr = addr; r.wren = wren;
      r.dat = dat; r.msk = msk; r.e_rdy = e_rdy; r.e_wrdy = e_wrdy;
      return r;
   endfunction

   localparam logic [127:0] D5  = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [127:0] D7  = 128'hFEDCBA98765432100F1E2D3C4B5A6978;
   localparam logic [127:0] DAA = 128'h1111_1111_1111_1111_1111_1111_1111_11AA;
   localparam logic [127:0] DB  = 128'hC0C0_0000_0000_0000_0000_0000_0000_0000;
   localparam logic [127:0] DW  = 128'hCAFE_F00D_DEAD_BEEF_0000_1111_2222_3333;

   vec_t tbl [$];

   initial begin
      logic [2:0]  rcmd;
      logic [27:0] raddr;
      int          r;

      tbl.push_back(v(1, APP_CMD_WRITE, 28'h5, 1, D5, 16'hFFFF, 1, 1));
      tbl.push_back(v(1, APP_CMD_READ,  28'h5, 0, 0,  16'h0,    1, 1));
      tbl.push_back(v(1, APP_CMD_WRITE, 28'h7, 0, 0,  16'h0,    1, 1));
      tbl.push_back(v(0, 3'b000,        28'h0, 0, 0,  16'h0,    0, 1));
      tbl.push_back(v(0, 3'b000,        28'h0, 0, 0,  16'h0,    0, 1));
      tbl.push_back(v(0, 3'b000,        28'h0, 1, D7, 16'hFFFF, 0, 1));
      tbl.push_back(v(1, APP_CMD_READ,  28'h7, 0, 0,  16'h0,    1, 1));
      tbl.push_back(v(1, APP_CMD_WRITE, 28'h9, 1, 0,  16'hFFFF, 1, 1));
      tbl.push_back(v(0, 3'b000,        28'h0, 1, DAA, 16'h0001, 1, 1));
      tbl.push_back(v(0, 3'b000,        28'h0, 0, 0,  16'h0,    1, 0));
      tbl.push_back(v(1, APP_CMD_WRITE, 28'h9, 0, 0,  16'h0,    1, 0));
      tbl.push_back(v(1, APP_CMD_READ,  28'h9, 0, 0,  16'h0,    1, 1));
      for (int k = 0; k < 4; k++)
         tbl.push_back(v(1, APP_CMD_WRITE, 28'(k), 1, DB + 128'(k), 16'hFFFF, 1, 1));
      for (int k = 0; k < 4; k++)
         tbl.push_back(v(1, APP_CMD_READ, 28'(k), 0, 0, 16'h0, 1, 1));
      tbl.push_back(v(1, 3'b111,        28'h0,   0, 0,  16'h0,    1, 1));
      tbl.push_back(v(0, 3'b000,        28'h0,   0, 0,  16'h0,    1, 1));
      tbl.push_back(v(1, APP_CMD_WRITE, 28'h5,   1, {4{32'hFFFF_FFFF}}, 16'h0, 1, 1));
      tbl.push_back(v(1, APP_CMD_READ,  28'h5,   0, 0,  16'h0,    1, 1));
      tbl.push_back(v(1, APP_CMD_READ,  28'h400, 0, 0,  16'h0,    1, 1));
      tbl.push_back(v(1, APP_CMD_WRITE, 28'h405, 1, DW, 16'hFFFF, 1, 1));
      tbl.push_back(v(1, APP_CMD_READ,  28'h5,   0, 0,  16'h0,    1, 1));

      do_reset();
      mon_en = 1'b1;

      foreach (tbl[i]) begin
         chk1("tbl_app_rdy", app_rdy, tbl[i].e_rdy);
         chk1("tbl_app_wdf_rdy", app_wdf_rdy, tbl[i].e_wrdy);
         step(tbl[i].en, tbl[i].cmd, tbl[i].addr, tbl[i].wren, tbl[i].dat, tbl[i].msk);
      end
      repeat (RL + 2) idle();

      // Hand-written sequences with literal expectations.
      chk1("err_cmd_sticky", err_cmd, 1'b1);
      rd_direct("rd_masked_0x9", 28'h9, 128'hAA);
      rd_direct("rd_late_0x7", 28'h7, D7);
      rd_direct("rd_0x5", 28'h5, RANGE_EN ? D5 : DW);
      rd_direct("rd_0x400", 28'h400, RANGE_EN ? 128'h0 : DB);
      chk1("err_range_after_0x400", err_range, RANGE_EN);

      // Random traffic over addresses 0..15, sometimes with high address bits.
      for (int a = 0; a < 16; a++)
         step(1'b1, APP_CMD_WRITE, 28'(a), 1'b1, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF);
      for (int n = 0; n < 400; n++) begin
         r = $urandom % 8;
         rcmd = (r < 3) ? APP_CMD_WRITE : (r < 7) ? APP_CMD_READ : 3'($urandom_range(2, 7));
         raddr = 28'($urandom % 16);
         if ($urandom % 8 == 0) raddr = raddr | (28'($urandom_range(1, 3)) << DL);
         r = $urandom % 4;
         step($urandom % 2 == 0, rcmd, raddr, $urandom % 3 == 0,
              {$urandom, $urandom, $urandom, $urandom},
              (r == 0) ? 16'h0 : (r == 1) ? 16'hFFFF : 16'($urandom));
      end
      repeat (RL + 2) idle();
      chk1("all_reads_returned", exp_q.size() == 0, 1'b1);

      // Reset with a buffered beat and two reads in flight.
      repeat (2) step(1'b0, 3'b000, 28'h0, 1'b1, DW, 16'hFFFF);
      step(1'b1, APP_CMD_READ, 28'h1, 1'b0, 128'h0, 16'h0);
      step(1'b1, APP_CMD_READ, 28'h2, 1'b0, 128'h0, 16'h0);
      do_reset();
      repeat (RL + 4) idle();
      // Storage survives reset.
      step(1'b1, APP_CMD_READ, 28'h3, 1'b0, 128'h0, 16'h0);
      repeat (RL + 2) idle();
      chk1("post_reset_reads_returned", exp_q.size() == 0, 1'b1);

      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
